apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Two-requester APB master for the peripheral subsystem. Drives the shared PSEL[3:0]/PENABLE/PADDR/PWDATA bus that feeds the RAM slave (slot 0) and the UART slave (slot 1).
- Arbitrates round-robin between two requesters (m0, m1) and decodes the target slave from the top two address bits.
- Sequences the APB SETUP/ACCESS phases and waits on PREADY. A timeout ends a hung transfer with an error.

Parameters:
- ADDR_WIDTH, 16, APB and requester address width.
- DATA_WIDTH, 32, APB and requester data width.
- SLAVE_EN, 4'b0011, bitmask of populated slave slots; a request to an unpopulated slot ends with an error.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before forced termination. 0 disables the timeout.

Ports:
- PCLK  in  1  system/APB clock.
- PRESET  in  1  synchronous, active-high reset.
- mN_valid  in  1  request from requester N (N=0,1). Held high until mN_done.
- mN_write  in  1  1=write, 0=read.
- mN_addr  in  ADDR_WIDTH  byte address.
- mN_wdata  in  DATA_WIDTH  write data.
- mN_strb  in  4  write byte strobes.
- mN_prot  in  3  protection attributes.
- mN_done  out  1  one-cycle completion pulse.
- mN_rdata  out  DATA_WIDTH  read data, valid while mN_done=1.
- mN_err  out  1  error flag, valid while mN_done=1.
- PSEL  out  4  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  4  APB strobes.
- PPROT  out  3  APB protection.
- PRDATA  in  DATA_WIDTH  muxed slave read data.
- PREADY  in  1  muxed slave ready.
- PSLVERR  in  1  muxed slave error.

Behaviour:
- Reset: PRESET is sampled on the PCLK rising edge.
  - All outputs go to 0 and the FSM goes to IDLE.
  - The round-robin pointer is set so that m0 wins the next tie.
  - Reset mid-transfer abandons the transfer: PSEL/PENABLE are 0 the next cycle and no mN_done is issued.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE, arbitration:
  - Eligible requester = mN_valid=1 and mN_done=0 in the same cycle, so the requester just completed is not re-granted.
  - Both eligible: grant the one not granted last. One eligible: grant it.
  - Slave index = addr[ADDR_WIDTH-1:ADDR_WIDTH-2].
  - If SLAVE_EN[index]=0: no APB cycle. Stay in IDLE; next cycle mN_done=1, mN_err=1, mN_rdata=0. Pointer updates.
  - Otherwise, at the edge: PSEL=onehot(index), PENABLE=0, request fields captured into PADDR/PWRITE/PWDATA/PPROT, PSTRB=strb (forced 4'b0 for reads). Go to SETUP.
- SETUP: one cycle. At the edge, PENABLE=1, timeout counter cleared, go to ACCESS.
- ACCESS:
  - PREADY=1: at the edge, PSEL=0 and PENABLE=0; mN_done=1, mN_rdata=PRDATA (0 on writes), mN_err=PSLVERR; go to IDLE.
  - PREADY=0: counter increments. When the count reaches TIMEOUT_CYCLES, end the transfer: PSEL/PENABLE drop, mN_done=1, mN_err=1, mN_rdata=0, go to IDLE.
- Latency: grant edge → SETUP (cycle 1) → ACCESS (cycle 2) → done (cycle 3) for zero wait states. Each wait state adds one cycle. Back-to-back throughput is one transfer per 3 cycles.
- Output stability:
  - PADDR/PWRITE/PWDATA/PSTRB/PPROT hold their values from SETUP through the end of ACCESS, and keep the last values in IDLE.
  - mN_done/mN_rdata/mN_err are registered. rdata/err are 0 whenever done=0.
- Requester changes to mN_* fields after grant are ignored. Dropping mN_valid mid-transfer does not abort the transfer; done still pulses.
- Only one of m0_done/m1_done is ever high in a cycle.

Test Plan:
- m0 write addr 0x0010, data 0xDEADBEEF, strb 4'hF, PREADY tied 1 → cycle 1: PSEL=0001, PENABLE=0, PWDATA=0xDEADBEEF; cycle 2: PENABLE=1; cycle 3: m0_done=1, m0_err=0, PSEL=0.
- m1 read addr 0x4004, slave inserts 2 wait states then PRDATA=0x12345678 → PSEL=0010, PSTRB=0, PENABLE high 3 cycles, m1_done with m1_rdata=0x12345678.
- m0 and m1 both valid continuously after reset, zero wait → grant order m0, m1, m0, m1; each done exactly 3 cycles apart.
- PREADY held 0, TIMEOUT_CYCLES=16 → PENABLE high 16 cycles, then PSEL=0, done=1, err=1, rdata=0.
- m0 read addr 0x8000 with SLAVE_EN=0011 → PSEL stays 0000; m0_done=1, m0_err=1 one cycle after grant.
- PRESET pulsed during ACCESS of an m1 write → next cycle PSEL=0, PENABLE=0; no m1_done; a following m0 request is granted normally.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side and APB-side signal bundle for apb_master_arbiter
//   master modport (arbiter view): mN_valid/write/addr/wdata/strb/prot in, mN_done/rdata/err out,
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT out, PRDATA/PREADY/PSLVERR in.
//   slave modport: the opposite directions, for whatever sits around the arbiter.
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_valid, m0_write, m0_done, m0_err;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;
  logic [3:0]            m0_strb;
  logic [2:0]            m0_prot;
  logic                  m1_valid, m1_write, m1_done, m1_err;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;
  logic [3:0]            m1_strb;
  logic [2:0]            m1_prot;
  logic [3:0]            PSEL;
  logic                  PENABLE, PWRITE, PREADY, PSLVERR;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA, PRDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  modport master (
    input  m0_valid, m0_write, m0_addr, m0_wdata, m0_strb, m0_prot,
    output m0_done, m0_rdata, m0_err,
    input  m1_valid, m1_write, m1_addr, m1_wdata, m1_strb, m1_prot,
    output m1_done, m1_rdata, m1_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    output m0_valid, m0_write, m0_addr, m0_wdata, m0_strb, m0_prot,
    input  m0_done, m0_rdata, m0_err,
    output m1_valid, m1_write, m1_addr, m1_wdata, m1_strb, m1_prot,
    input  m1_done, m1_rdata, m1_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master with slave decode and ACCESS timeout
//   PCLK   clock, PRESET synchronous active-high reset
//   bus    apb_master_arbiter_if.master: requester handshakes (m0/m1) and the shared APB bus
module apb_master_arbiter #(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [3:0] SLAVE_EN       = 4'b0011,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input logic                  PCLK,
  input logic                  PRESET,
  apb_master_arbiter_if.master bus
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                r_state, w_next;
  logic                  r_grant, r_last, r_err, r_penable, r_pwrite;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_done;
  logic [DATA_WIDTH-1:0] r_rdata, r_pwdata;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [3:0]            r_psel, r_pstrb;
  logic [2:0]            r_pprot;
  logic                  w_e0, w_e1, w_any, w_pick, w_hit, w_start, w_bad, w_to, w_fin;
  logic                  w_write, w_err, w_penable;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [1:0]            w_idx, w_done;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [3:0]            w_psel;
  // a requester whose done is high this cycle is not eligible, so it cannot be re-granted
  assign w_e0    = bus.m0_valid & ~r_done[0];
  assign w_e1    = bus.m1_valid & ~r_done[1];
  assign w_any   = w_e0 | w_e1;
  assign w_pick  = (w_e0 & w_e1) ? ~r_last : w_e1;
  assign w_addr  = w_pick ? bus.m1_addr : bus.m0_addr;
  assign w_write = w_pick ? bus.m1_write : bus.m0_write;
  assign w_idx   = w_addr[ADDR_WIDTH-1 -: 2];
  assign w_hit   = SLAVE_EN[w_idx];
  assign w_start = r_state == IDLE && w_any && w_hit;
  assign w_bad   = r_state == IDLE && w_any && !w_hit;
  // r_cnt counts completed wait cycles, so reaching LAST with PREADY low is the final allowed one
  assign w_to    = TIMEOUT_CYCLES != 0 && r_cnt == LAST && !bus.PREADY;
  assign w_fin   = r_state == ACCESS && (bus.PREADY || w_to);
  always_ff @(posedge PCLK) r_state <= PRESET ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE ? (w_start ? SETUP : IDLE) :
             r_state == SETUP ? ACCESS : (w_fin ? IDLE : ACCESS);
  always_comb begin
    w_done    = w_fin ? (r_grant ? 2'b10 : 2'b01) : w_bad ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
    w_err     = w_bad || (w_fin && (!bus.PREADY || bus.PSLVERR));
    w_rdata   = (w_fin && bus.PREADY && !r_pwrite) ? bus.PRDATA : '0;
    w_psel    = w_start ? 4'b0001 << w_idx : w_fin ? 4'b0000 : r_psel;
    w_penable = r_state == SETUP ? 1'b1 : w_fin ? 1'b0 : r_penable;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
    end else begin
      r_done    <= w_done;
      r_err     <= w_err;
      r_rdata   <= w_rdata;
      r_psel    <= w_psel;
      r_penable <= w_penable;
      r_cnt     <= r_state == ACCESS ? r_cnt + 1'b1 : '0;
      if (w_start || w_bad) r_last <= w_pick;
      if (w_start) begin
        r_grant  <= w_pick;
        r_pwrite <= w_write;
        r_paddr  <= w_addr;
        r_pwdata <= w_pick ? bus.m1_wdata : bus.m0_wdata;
        r_pstrb  <= w_write ? (w_pick ? bus.m1_strb : bus.m0_strb) : 4'b0000;
        r_pprot  <= w_pick ? bus.m1_prot : bus.m0_prot;
      end
    end
  end
  assign bus.m0_done  = r_done[0];
  assign bus.m1_done  = r_done[1];
  assign bus.m0_err   = r_done[0] & r_err;
  assign bus.m1_err   = r_done[1] & r_err;
  assign bus.m0_rdata = r_done[0] ? r_rdata : '0;
  assign bus.m1_rdata = r_done[1] ? r_rdata : '0;
  assign bus.PSEL     = r_psel;
  assign bus.PENABLE  = r_penable;
  assign bus.PWRITE   = r_pwrite;
  assign bus.PADDR    = r_paddr;
  assign bus.PWDATA   = r_pwdata;
  assign bus.PSTRB    = r_pstrb;
  assign bus.PPROT    = r_pprot;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized transaction-level check of apb_master_arbiter
module tb_apb_master_arbiter;
  localparam int AW = 16, DW = 32, TO = 16;
  localparam logic [3:0] SEN = 4'b0011;
  logic PCLK = 1'b0, PRESET = 1'b1;
  int n_vec = 0, n_err = 0;
  int last = 1;
  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_EN(SEN), .TIMEOUT_CYCLES(TO))
    dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));
  always #5 PCLK = ~PCLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int m, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] s, input logic [2:0] p);
    if (m == 0) begin
      bus.m0_valid = v; bus.m0_write = w; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_strb = s; bus.m0_prot = p;
    end else begin
      bus.m1_valid = v; bus.m1_write = w; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_strb = s; bus.m1_prot = p;
    end
  endtask
  function automatic logic done_of(input int m);
    return m == 0 ? bus.m0_done : bus.m1_done;
  endfunction
  function automatic logic err_of(input int m);
    return m == 0 ? bus.m0_err : bus.m1_err;
  endfunction
  function automatic logic [DW-1:0] rdata_of(input int m);
    return m == 0 ? bus.m0_rdata : bus.m1_rdata;
  endfunction
  // one transaction from requester m; the slave answers after 'waits' wait states
  task automatic do_txn(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input logic [2:0] p, input int waits,
                        input logic slv, input logic [DW-1:0] rd);
    logic [1:0] slot = a[AW-1 -: 2];
    bit bad = !SEN[slot];
    bit tout = !bad && waits >= TO;
    int lat = bad ? 1 : tout ? 2 + TO : 3 + waits;
    int exp_acc = bad ? 0 : tout ? TO : waits + 1;
    bit exp_err = bad || tout || slv;
    logic [DW-1:0] exp_rd = (bad || tout || w) ? '0 : rd;
    int cyc = 0, acc = 0;
    bit got = 0;
    @(negedge PCLK);
    drive(m, 1'b1, w, a, d, s, p);
    bus.PREADY = 1'b0; bus.PRDATA = rd; bus.PSLVERR = slv;
    while (!got && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
      check("done_excl", 64'(bus.m0_done & bus.m1_done), 0);
      if (done_of(m)) begin
        got = 1;
        check("latency", cyc, lat);
        check("access_cycles", acc, exp_acc);
        check("err", err_of(m), exp_err);
        check("rdata", rdata_of(m), exp_rd);
        check("psel_end", bus.PSEL, 0);
        check("penable_end", bus.PENABLE, 0);
      end else if (bus.PSEL != 4'b0000) begin
        check("psel", bus.PSEL, 4'b0001 << slot);
        check("paddr", bus.PADDR, a);
        check("pwrite", bus.PWRITE, w);
        check("pwdata", bus.PWDATA, d);
        check("pstrb", bus.PSTRB, w ? s : 4'h0);
        check("pprot", bus.PPROT, p);
        if (bus.PENABLE) begin
          acc++;
          bus.PREADY = (acc == waits + 1);
        end else drive(m, 1'b1, 1'($urandom), AW'($urandom), $urandom, 4'($urandom), 3'($urandom));
      end
    end
    check("done_seen", 64'(got), 1);
    drive(m, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.PREADY = 1'b0;
    last = m;
    @(negedge PCLK);
    check("done_pulse", done_of(m), 0);
    check("rdata_idle", rdata_of(m), 0);
  endtask
  task automatic rnd_txn(input int m);
    logic [1:0] slot = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    int waits = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
    do_txn(m, 1'($urandom), {slot, 14'($urandom)}, $urandom, 4'($urandom), 3'($urandom), waits,
           $urandom_range(0, 3) == 0, $urandom);
  endtask
  // both requesters hold valid; completions must alternate starting with 'first', 3 cycles apart
  task automatic both(input int n, input int first);
    int cyc = 0, prev = 0, k = 0, exp_m = first;
    @(negedge PCLK);
    drive(0, 1'b1, 1'b1, 16'h0020, $urandom, 4'hF, 3'b000);
    drive(1, 1'b1, 1'b1, 16'h4020, $urandom, 4'hF, 3'b001);
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = $urandom;
    while (k < n && cyc < 20 * n) begin
      @(negedge PCLK);
      cyc++;
      check("arb_excl", 64'(bus.m0_done & bus.m1_done), 0);
      if (bus.m0_done || bus.m1_done) begin
        check("arb_who", 64'(bus.m1_done), exp_m);
        check("arb_gap", cyc - prev, 3);
        check("arb_err", 64'(bus.m0_err | bus.m1_err), 0);
        check("arb_rdata", bus.m0_rdata | bus.m1_rdata, 0);
        last = bus.m1_done ? 1 : 0;
        prev = cyc;
        exp_m ^= 1;
        k++;
        if (k == n) begin
          drive(0, 1'b0, 1'b0, '0, '0, '0, '0);
          drive(1, 1'b0, 1'b0, '0, '0, '0, '0);
        end
      end
    end
    check("arb_count", k, n);
    drive(0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.PREADY = 1'b0;
    repeat (2) @(negedge PCLK);
    check("arb_idle", bus.PSEL, 0);
  endtask
  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    last = 1;
  endtask
  initial begin
    int n = 0;
    drive(0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_done", {bus.m1_done, bus.m0_done}, 0);
    check("rst_err", {bus.m1_err, bus.m0_err}, 0);
    check("rst_paddr", bus.PADDR, 0);
    do_txn(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 1'b0, 32'hCAFEF00D);
    do_txn(1, 1'b0, 16'h4004, 32'h0BADF00D, 4'hF, 3'b010, 2, 1'b0, 32'h12345678);
    do_txn(0, 1'b0, 16'h0100, 32'h0, 4'h0, 3'b000, TO, 1'b0, 32'h55AA55AA);
    do_txn(0, 1'b0, 16'h8000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h11111111);
    do_txn(1, 1'b1, 16'h4010, 32'hA5A5A5A5, 4'h3, 3'b111, 1, 1'b1, 32'h0);
    do_reset();
    both(4, 0);
    repeat (40) rnd_txn($urandom_range(0, 1));
    repeat (6) begin
      int solo = $urandom_range(0, 1);
      rnd_txn(solo);
      both(2, 1 - last);
    end
    @(negedge PCLK);
    drive(1, 1'b1, 1'b1, 16'h4008, 32'h13572468, 4'hF, 3'b000);
    bus.PREADY = 1'b0;
    while (!bus.PENABLE && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    check("rst_mid_access", 64'(bus.PENABLE), 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    last = 1;
    drive(1, 1'b0, 1'b0, '0, '0, '0, '0);
    check("rst_mid_psel", bus.PSEL, 0);
    check("rst_mid_penable", bus.PENABLE, 0);
    check("rst_mid_done", 64'(bus.m1_done), 0);
    repeat (4) begin
      @(negedge PCLK);
      check("rst_no_done", 64'(bus.m1_done), 0);
    end
    do_txn(0, 1'b0, 16'h0044, 32'h0, 4'h0, 3'b001, 0, 1'b0, 32'h87654321);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
